// File: rtl/dh_pkg.sv
// dh_pkg: shared types and limits for the Duck Hunt game-flow blocks.
// Rev 1.0
`default_nettype none

package dh_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BANNER,
      LAUNCH,
      FLIGHT,
      HIT_ANIM,
      ESCAPE,
      ROUND_END,
      GAME_OVER
   } round_state_t;

   localparam int MAX_ROUND   = 99;
   localparam int H_SPEED_MAX = 31;

   // Duck speed for a given round: one step faster per round, clamped.
   function automatic logic [4:0] speed_for_round(input int base, input logic [6:0] rnd);
      int s;
      s = base + int'(rnd) - 1;
      return (s > H_SPEED_MAX) ? 5'(H_SPEED_MAX) : 5'(s);
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter of frame ticks with a pause gate; done fires on the tick seen at zero.
// Rev 1.0
`default_nettype none

module frame_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   input  logic             pause,
   output logic             done
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (tick && !pause && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Combinational so a frame pulse moves the sequencer on the very next edge.
   assign done = tick & ~pause & (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ctl_round.sv
// ctl_round: Duck Hunt game-flow sequencer (banner, launch, flight, hit/escape, round evaluation, game over).
// Optional macro CTL_ROUND_SPEEDUP_EN raises h_speed by one per round. Rev 1.0
`default_nettype none

module ctl_round
   import dh_pkg::*;
#(
   parameter int DUCKS_PER_ROUND = 10,
   parameter int SHOTS_PER_DUCK  = 3,
   parameter int PASS_HITS       = 6,
   parameter int BANNER_FRAMES   = 120,
   parameter int FLIGHT_FRAMES   = 600,
   parameter int ANIM_FRAMES     = 60,
   parameter int H_SPEED_BASE    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_frame,
   input  logic       start,
   input  logic       pause,
   input  logic       hit,
   input  logic       shot_fired,
   output logic       duck_launch,
   output logic       duck_active,
   output logic       duck_falling,
   output logic       ammo_reload,
   output logic       banner_on,
   output logic       game_over,
   output logic [6:0] round_num,
   output logic [3:0] ducks_hit,
   output logic [3:0] duck_idx,
   output logic [1:0] shots_left,
   output logic [4:0] h_speed
);

   localparam logic [9:0] C_BANNER_LD = 10'(BANNER_FRAMES - 1);
   localparam logic [9:0] C_FLIGHT_LD = 10'(FLIGHT_FRAMES - 1);
   localparam logic [9:0] C_ANIM_LD   = 10'(ANIM_FRAMES - 1);
   localparam logic [3:0] C_LAST_IDX  = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [1:0] C_SHOTS     = 2'(SHOTS_PER_DUCK);

   round_state_t r_state;
   round_state_t w_state_nx;
   logic [6:0]   w_round_nx;
   logic [3:0]   w_hits_nx;
   logic [3:0]   w_idx_nx;
   logic [1:0]   w_shots_nx;
   logic         w_tmr_load;
   logic [9:0]   w_tmr_val;
   logic         w_tmr_done;
   logic         w_run;

   assign w_run = ~pause;

   frame_timer #(
      .WIDTH (10)
   ) u_frame_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .tick     (new_frame),
      .pause    (pause),
      .done     (w_tmr_done)
   );

   always_comb begin
      w_state_nx = r_state;
      w_round_nx = round_num;
      w_hits_nx  = ducks_hit;
      w_idx_nx   = duck_idx;
      w_shots_nx = shots_left;

      case (r_state)
         IDLE, GAME_OVER: begin
            if (start) begin
               w_state_nx = BANNER;
               w_round_nx = 7'd1;
               w_hits_nx  = 4'd0;
               w_idx_nx   = 4'd0;
            end
         end
         BANNER: begin
            if (w_tmr_done) w_state_nx = LAUNCH;
         end
         LAUNCH: begin
            // Launch always completes, even under pause; FLIGHT then holds.
            w_state_nx = FLIGHT;
         end
         FLIGHT: begin
            if (w_run) begin
               if (hit) begin
                  w_state_nx = HIT_ANIM;
                  w_hits_nx  = (ducks_hit == 4'd15) ? ducks_hit : ducks_hit + 4'd1;
               end else if (shot_fired) begin
                  w_shots_nx = shots_left - 2'd1;
                  if (shots_left <= 2'd1) w_state_nx = ESCAPE;
               end else if (w_tmr_done) begin
                  w_state_nx = ESCAPE;
               end
            end
         end
         HIT_ANIM, ESCAPE: begin
            if (w_tmr_done) begin
               if (duck_idx == C_LAST_IDX) begin
                  w_state_nx = ROUND_END;
               end else begin
                  w_idx_nx   = duck_idx + 4'd1;
                  w_state_nx = LAUNCH;
               end
            end
         end
         ROUND_END: begin
            if (w_run) begin
               if (int'(ducks_hit) >= PASS_HITS) begin
                  w_round_nx = (int'(round_num) >= MAX_ROUND) ? round_num : round_num + 7'd1;
                  w_hits_nx  = 4'd0;
                  w_idx_nx   = 4'd0;
                  w_state_nx = BANNER;
               end else begin
                  w_state_nx = GAME_OVER;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase

      if ((w_state_nx == LAUNCH) && (r_state != LAUNCH)) w_shots_nx = C_SHOTS;

      // Every state entry restarts the frame count for that state's wait.
      w_tmr_load = (w_state_nx != r_state);
      case (w_state_nx)
         BANNER:           w_tmr_val = C_BANNER_LD;
         FLIGHT:           w_tmr_val = C_FLIGHT_LD;
         HIT_ANIM, ESCAPE: w_tmr_val = C_ANIM_LD;
         default:          w_tmr_val = 10'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         round_num    <= 7'd1;
         ducks_hit    <= 4'd0;
         duck_idx     <= 4'd0;
         shots_left   <= C_SHOTS;
         duck_launch  <= 1'b0;
         ammo_reload  <= 1'b0;
         duck_active  <= 1'b0;
         duck_falling <= 1'b0;
         banner_on    <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         round_num    <= w_round_nx;
         ducks_hit    <= w_hits_nx;
         duck_idx     <= w_idx_nx;
         shots_left   <= w_shots_nx;
         duck_launch  <= (w_state_nx == LAUNCH);
         ammo_reload  <= (w_state_nx == LAUNCH);
         duck_active  <= (w_state_nx == FLIGHT);
         duck_falling <= (w_state_nx == HIT_ANIM);
         banner_on    <= (w_state_nx == BANNER);
         game_over    <= (w_state_nx == GAME_OVER);
      end
   end

`ifdef CTL_ROUND_SPEEDUP_EN
   logic [4:0] r_speed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speed <= 5'(H_SPEED_BASE);
      end else if ((r_state == ROUND_END) && (w_state_nx == BANNER)) begin
         r_speed <= speed_for_round(H_SPEED_BASE, w_round_nx);
      end else if ((r_state == IDLE || r_state == GAME_OVER) && (w_state_nx == BANNER)) begin
         r_speed <= 5'(H_SPEED_BASE);
      end
   end

   assign h_speed = r_speed;
`else
   assign h_speed = 5'(H_SPEED_BASE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctl_round.sv
// tb_ctl_round: directed self-checking bench for the ctl_round game-flow sequencer.
// Rev 1.0
`default_nettype none

module tb_ctl_round;

   logic       clk;
   logic       rst;
   logic       new_frame;
   logic       start;
   logic       pause;
   logic       hit;
   logic       shot_fired;
   logic       duck_launch;
   logic       duck_active;
   logic       duck_falling;
   logic       ammo_reload;
   logic       banner_on;
   logic       game_over;
   logic [6:0] round_num;
   logic [3:0] ducks_hit;
   logic [3:0] duck_idx;
   logic [1:0] shots_left;
   logic [4:0] h_speed;

   int n_cmp;
   int n_err;

`ifdef CTL_ROUND_SPEEDUP_EN
   localparam int SPEED_R2 = 11;
`else
   localparam int SPEED_R2 = 10;
`endif

   ctl_round #(
      .DUCKS_PER_ROUND (3),
      .SHOTS_PER_DUCK  (3),
      .PASS_HITS       (2),
      .BANNER_FRAMES   (2),
      .FLIGHT_FRAMES   (5),
      .ANIM_FRAMES     (2),
      .H_SPEED_BASE    (10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .new_frame    (new_frame),
      .start        (start),
      .pause        (pause),
      .hit          (hit),
      .shot_fired   (shot_fired),
      .duck_launch  (duck_launch),
      .duck_active  (duck_active),
      .duck_falling (duck_falling),
      .ammo_reload  (ammo_reload),
      .banner_on    (banner_on),
      .game_over    (game_over),
      .round_num    (round_num),
      .ducks_hit    (ducks_hit),
      .duck_idx     (duck_idx),
      .shots_left   (shots_left),
      .h_speed      (h_speed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given pulses applied; outputs are sampled 1 ns after the edge.
   task automatic cyc(input logic f, input logic st, input logic h, input logic sh);
      new_frame  = f;
      start      = st;
      hit        = h;
      shot_fired = sh;
      @(posedge clk);
      #1;
      new_frame  = 1'b0;
      start      = 1'b0;
      hit        = 1'b0;
      shot_fired = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({round_num, ducks_hit, duck_idx, shots_left} !== {7'd1, 4'd0, 4'd0, 2'd3}) begin
         n_err++;
         $display("FAIL reset_counters: got r%0d h%0d i%0d s%0d, want r1 h0 i0 s3",
                  round_num, ducks_hit, duck_idx, shots_left);
      end
      n_cmp++;
      if ({duck_launch, duck_active, duck_falling, ammo_reload, banner_on, game_over} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_levels: got %b want 000000",
                  {duck_launch, duck_active, duck_falling, ammo_reload, banner_on, game_over});
      end
      n_cmp++;
      if (h_speed !== 5'd10) begin
         n_err++;
         $display("FAIL reset_speed: got %0d want 10", h_speed);
      end
   endtask

   task automatic test_start_launch;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (banner_on !== 1'b1) begin
         n_err++;
         $display("FAIL banner_after_start: got %b want 1", banner_on);
      end
      frames(1);
      n_cmp++;
      if ({banner_on, duck_launch} !== 2'b10) begin
         n_err++;
         $display("FAIL banner_frame1: got %b want 10", {banner_on, duck_launch});
      end
      frames(1);
      n_cmp++;
      if ({banner_on, duck_launch, ammo_reload, shots_left} !== {3'b011, 2'd3}) begin
         n_err++;
         $display("FAIL launch_pulse: got b%b l%b a%b s%0d want b0 l1 a1 s3",
                  banner_on, duck_launch, ammo_reload, shots_left);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({duck_active, duck_launch, ammo_reload} !== 3'b100) begin
         n_err++;
         $display("FAIL flight_entry: got %b want 100", {duck_active, duck_launch, ammo_reload});
      end
   endtask

   task automatic test_shots_escape;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (shots_left !== 2'd2) begin
         n_err++;
         $display("FAIL shot1: got %0d want 2", shots_left);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({shots_left, duck_active} !== {2'd1, 1'b1}) begin
         n_err++;
         $display("FAIL shot2: got s%0d act%b want s1 act1", shots_left, duck_active);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({shots_left, duck_active, duck_falling} !== {2'd0, 2'b00}) begin
         n_err++;
         $display("FAIL shot3_escape: got s%0d act%b fall%b want s0 act0 fall0",
                  shots_left, duck_active, duck_falling);
      end
      frames(1);
      n_cmp++;
      if ({duck_launch, duck_idx} !== {1'b0, 4'd0}) begin
         n_err++;
         $display("FAIL escape_frame1: got l%b i%0d want l0 i0", duck_launch, duck_idx);
      end
      frames(1);
      n_cmp++;
      if ({duck_launch, duck_idx, shots_left} !== {1'b1, 4'd1, 2'd3}) begin
         n_err++;
         $display("FAIL relaunch: got l%b i%0d s%0d want l1 i1 s3", duck_launch, duck_idx, shots_left);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_hit_and_shot;
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if ({duck_falling, duck_active, ducks_hit, shots_left} !== {2'b10, 4'd1, 2'd3}) begin
         n_err++;
         $display("FAIL hit_wins: got fall%b act%b h%0d s%0d want fall1 act0 h1 s3",
                  duck_falling, duck_active, ducks_hit, shots_left);
      end
      frames(2);
      n_cmp++;
      if ({duck_launch, duck_idx} !== {1'b1, 4'd2}) begin
         n_err++;
         $display("FAIL launch_duck2: got l%b i%0d want l1 i2", duck_launch, duck_idx);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_round_pass;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (ducks_hit !== 4'd2) begin
         n_err++;
         $display("FAIL second_hit: got %0d want 2", ducks_hit);
      end
      frames(2);
      n_cmp++;
      if ({duck_launch, banner_on, duck_falling, game_over} !== 4'b0000) begin
         n_err++;
         $display("FAIL round_end_levels: got %b want 0000",
                  {duck_launch, banner_on, duck_falling, game_over});
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({round_num, ducks_hit, duck_idx, banner_on} !== {7'd2, 4'd0, 4'd0, 1'b1}) begin
         n_err++;
         $display("FAIL round_pass: got r%0d h%0d i%0d b%b want r2 h0 i0 b1",
                  round_num, ducks_hit, duck_idx, banner_on);
      end
      n_cmp++;
      if (int'(h_speed) != SPEED_R2) begin
         n_err++;
         $display("FAIL speed_round2: got %0d want %0d", h_speed, SPEED_R2);
      end
      frames(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_pause;
      frames(2);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, (i % 3) == 0, (i % 4) == 1);
      n_cmp++;
      if ({duck_active, duck_falling, ducks_hit, shots_left} !== {2'b10, 4'd0, 2'd3}) begin
         n_err++;
         $display("FAIL pause_hold: got act%b fall%b h%0d s%0d want act1 fall0 h0 s3",
                  duck_active, duck_falling, ducks_hit, shots_left);
      end
      pause = 1'b0;
      frames(2);
      n_cmp++;
      if (duck_active !== 1'b1) begin
         n_err++;
         $display("FAIL pause_resume_early: got %b want 1", duck_active);
      end
      frames(1);
      n_cmp++;
      if ({duck_active, duck_falling} !== 2'b00) begin
         n_err++;
         $display("FAIL pause_resume_escape: got %b want 00", {duck_active, duck_falling});
      end
   endtask

   task automatic test_game_over;
      frames(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      frames(5);
      n_cmp++;
      if ({duck_active, duck_idx} !== {1'b0, 4'd1}) begin
         n_err++;
         $display("FAIL timeout_escape: got act%b i%0d want act0 i1", duck_active, duck_idx);
      end
      frames(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      frames(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if ({game_over, round_num, ducks_hit} !== {1'b1, 7'd2, 4'd1}) begin
         n_err++;
         $display("FAIL game_over: got go%b r%0d h%0d want go1 r2 h1", game_over, round_num, ducks_hit);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({game_over, banner_on, round_num, ducks_hit, h_speed} !== {2'b01, 7'd1, 4'd0, 5'd10}) begin
         n_err++;
         $display("FAIL restart: got go%b b%b r%0d h%0d spd%0d want go0 b1 r1 h0 spd10",
                  game_over, banner_on, round_num, ducks_hit, h_speed);
      end
   endtask

   task automatic test_outside_flight_and_reset;
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if ({banner_on, ducks_hit, shots_left} !== {1'b1, 4'd0, 2'd3}) begin
         n_err++;
         $display("FAIL ignore_in_banner: got b%b h%0d s%0d want b1 h0 s3", banner_on, ducks_hit, shots_left);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({banner_on, duck_launch, ammo_reload} !== 3'b000) begin
         n_err++;
         $display("FAIL async_reset: got %b want 000", {banner_on, duck_launch, ammo_reload});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      pause = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      frames(3);
      n_cmp++;
      if ({banner_on, duck_launch} !== 2'b10) begin
         n_err++;
         $display("FAIL pause_start_idle: got %b want 10", {banner_on, duck_launch});
      end
      pause = 1'b0;
      frames(2);
      n_cmp++;
      if (duck_launch !== 1'b1) begin
         n_err++;
         $display("FAIL launch_after_unpause: got %b want 1", duck_launch);
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b0;
      new_frame  = 1'b0;
      start      = 1'b0;
      pause      = 1'b0;
      hit        = 1'b0;
      shot_fired = 1'b0;
      #2;
      test_reset;
      test_start_launch;
      test_shots_escape;
      test_hit_and_shot;
      test_round_pass;
      test_pause;
      test_game_over;
      test_outside_flight_and_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ctl_round.md
Name: ctl_round

Overview:
Game-flow sequencer for Duck Hunt. It takes per-shot results from the trigger/hit logic and the frame tick from VGA timing, and steps through banner, duck launch, flight, hit/escape animation, round evaluation and game over. Its outputs drive the duck controller (launch, active), the ammo counter (reload), the overlay (banner, game over) and the score display (round, hits).

Parameters:
- DUCKS_PER_ROUND, 10: ducks launched per round (1..15).
- SHOTS_PER_DUCK, 3: shots allowed per duck (1..3).
- PASS_HITS, 6: hits needed in a round to advance.
- BANNER_FRAMES, 120: frames the round banner is shown.
- FLIGHT_FRAMES, 600: frames before an unhit duck escapes.
- ANIM_FRAMES, 60: frames for hit-fall or escape animation.
- H_SPEED_BASE, 10: base horizontal duck speed.

Ports:
- clk  in  1  main 65 MHz clock
- rst  in  1  asynchronous active-high reset
- new_frame  in  1  one-cycle pulse per VGA frame
- start  in  1  one-cycle start pulse (debounced tick)
- pause  in  1  level; freezes sequencing
- hit  in  1  one-cycle pulse: shot hit target
- shot_fired  in  1  one-cycle pulse: any shot
- duck_launch  out  1  one-cycle pulse: ctl_duck loads new start position
- duck_active  out  1  high while the duck is in FLIGHT
- duck_falling  out  1  high in HIT_ANIM
- ammo_reload  out  1  one-cycle pulse coincident with duck_launch
- banner_on  out  1  high in BANNER
- game_over  out  1  high in GAME_OVER
- round_num  out  7  current round, 1..99
- ducks_hit  out  4  hits in the current round
- duck_idx  out  4  index of the current duck, 0-based
- shots_left  out  2  shots remaining for the current duck
- h_speed  out  5  horizontal speed sent to ctl_duck

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - round_num = 1; ducks_hit = 0; duck_idx = 0; shots_left = SHOTS_PER_DUCK.
  - All pulse and level outputs = 0.
  - h_speed = H_SPEED_BASE.
- frame_cnt (10 b) counts `new_frame` pulses. It clears on every state entry.
- States and transitions:
  - IDLE: `start` → BANNER. Clears round_num to 1, ducks_hit to 0, duck_idx to 0.
  - BANNER: frame_cnt == BANNER_FRAMES-1 at a `new_frame` → LAUNCH.
  - LAUNCH: lasts exactly one cycle. duck_launch = ammo_reload = 1, shots_left = SHOTS_PER_DUCK, then → FLIGHT.
  - FLIGHT:
    - `hit` → HIT_ANIM; ducks_hit increments, saturating at 15.
    - Otherwise `shot_fired` decrements shots_left. Reaching 0 → ESCAPE.
    - Otherwise frame_cnt == FLIGHT_FRAMES-1 at a `new_frame` → ESCAPE.
  - HIT_ANIM / ESCAPE: after ANIM_FRAMES frames:
    - If duck_idx == DUCKS_PER_ROUND-1 → ROUND_END.
    - Otherwise duck_idx increments → LAUNCH.
  - ROUND_END: lasts one cycle.
    - ducks_hit >= PASS_HITS: round_num increments (saturating at 99), ducks_hit = 0, duck_idx = 0 → BANNER.
    - Otherwise → GAME_OVER.
  - GAME_OVER: holds round_num and ducks_hit. `start` → BANNER, with the same clears as from IDLE.
- Simultaneous `hit` and `shot_fired` in FLIGHT: the hit wins; shots_left is unchanged.
- `hit` or `shot_fired` outside FLIGHT is ignored.
- While `pause` = 1:
  - State, counters and frame_cnt are held.
  - hit, shot_fired and new_frame are ignored.
  - `start` is ignored except in IDLE and GAME_OVER.
  - A LAUNCH cycle in progress completes its pulse; the FLIGHT entry then holds.
- Latency: input pulse → output/state change is one cycle.
- Reset mid-game returns to IDLE immediately, with no pulses emitted.

Optional Feature:
Macro CTL_ROUND_SPEEDUP_EN.
- Defined: h_speed = min(H_SPEED_BASE + round_num - 1, 31), registered and updated at ROUND_END.
- Undefined: h_speed is constant H_SPEED_BASE.

Decomposition:
- Package dh_pkg holds:
  - typedef enum logic [2:0] round_state_t: IDLE, BANNER, LAUNCH, FLIGHT, HIT_ANIM, ESCAPE, ROUND_END, GAME_OVER.
  - Constants MAX_ROUND = 99 and H_SPEED_MAX = 31.
- One natural sub-module, frame_timer: a loadable down-counter of `new_frame` with a pause gate and a `done` pulse. It is shared by the BANNER, FLIGHT and animation waits.

Test Plan:
- Test params: BANNER_FRAMES=2, FLIGHT_FRAMES=5, ANIM_FRAMES=2, DUCKS_PER_ROUND=3, PASS_HITS=2.
- Reset, then start, then 2 frames → banner_on high for 2 frames; duck_launch and ammo_reload pulse together for 1 cycle; duck_active = 1; shots_left = 3.
- In FLIGHT, 3× shot_fired with no hit → shots_left 3→2→1→0, ESCAPE entered; after 2 frames duck_idx = 1 and duck_launch pulses again.
- hit and shot_fired in the same cycle → HIT_ANIM, duck_falling = 1, ducks_hit = 1, shots_left still 3.
- Three ducks with 2 hits → ROUND_END → round_num = 2, ducks_hit = 0, banner_on = 1. With 1 hit → game_over = 1; a later start → round_num = 1, BANNER.
- pause held for 10 frames during FLIGHT, with hit pulses injected → state, frame_cnt and ducks_hit unchanged; after release, escape occurs after the remaining frames.
- With CTL_ROUND_SPEEDUP_EN: h_speed reads 10 in round 1 and 11 after the first pass. Forcing round 23 → 31 (saturated). Without the macro, h_speed is always 10.
